// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
//   Shared types and helpers for the PLL lock sequencer.
//   - state_t    : sequencer FSM states.
//   - cnt_w()    : counter width for a modulo-n counter. It is never narrower
//                  than 1 bit.
//   - LOSS_CNT_* : width and saturation value of the lock-loss event counter.
// ---------------------------------------------------------------------------
package pll_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int         LOSS_CNT_W   = 8;
    localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

    // Width needed to count 0..n-1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// ---------------------------------------------------------------------------
// pll_lock_sync
//   A SYNC_STAGES-deep single-bit synchroniser. It has an asynchronous
//   active-low clear to 0.
//   The sequencer uses it twice:
//   - for the asynchronous pll_locked flag;
//   - for the rst_n release, with d tied high. In that use, assertion of
//     rst_n passes through immediately and deassertion is retimed.
// Ports
//   clk    in  1  destination clock
//   clr_n  in  1  asynchronous active-low clear
//   d      in  1  asynchronous input bit
//   q      out 1  synchronised output
// ---------------------------------------------------------------------------
module pll_lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_p;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//   Purpose
//     Watches the PLL lock flag. It releases the core reset only after lock
//     has been stable for LOCK_STABLE_CYCLES cycles, followed by a
//     RESET_HOLD_CYCLES hold with the clock enables already running.
//     It generates two phase-aligned clock-enable strobes:
//     - ce_a, once every CE_DIV_A cycles;
//     - ce_b, once every CE_DIV_B cycles.
//     A lock drop in HOLD or RUN returns the sequencer to WAIT_LOCK and sets
//     the sticky lock_lost flag.
//   Ports
//     clk_sys        in   1  system clock (PLL outclk 0)
//     rst_n          in   1  asynchronous active-low reset; release is synchronised
//     pll_locked     in   1  PLL lock flag, asynchronous to clk_sys
//     sys_reset      out  1  active-high core reset
//     ready          out  1  high while in RUN
//     ce_a           out  1  1-cycle strobe every CE_DIV_A cycles (HOLD/RUN)
//     ce_b           out  1  1-cycle strobe every CE_DIV_B cycles, coincides with ce_a
//     lock_lost      out  1  sticky lock-loss flag, cleared only by rst_n
//     lock_loss_cnt  out  8  saturating lock-loss event count
//   Configuration
//     PLL_LOCK_LOSS_CNT_EN
//       - defined: lock_loss_cnt counts lock-loss events from HOLD or RUN and
//         saturates at 255.
//       - undefined: lock_loss_cnt is tied to 0.
//   RESET_HOLD_CYCLES must be a multiple of CE_DIV_B. With that, the first
//   RUN cycle always carries both strobes.
// ---------------------------------------------------------------------------
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 64,
    parameter int CE_DIV_A           = 4,
    parameter int CE_DIV_B           = 16
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       sys_reset,
    output logic       ready,
    output logic       ce_a,
    output logic       ce_b,
    output logic       lock_lost,
    output logic [7:0] lock_loss_cnt
);

    localparam int STABLE_W = cnt_w(LOCK_STABLE_CYCLES);
    localparam int HOLD_W   = cnt_w(RESET_HOLD_CYCLES);
    localparam int DIV_W    = cnt_w(CE_DIV_B);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(CE_DIV_B - 1);
    // CE_DIV_A is a power of two, so div_cnt % CE_DIV_A is a mask of the low bits.
    localparam logic [DIV_W-1:0]    A_MASK      = DIV_W'(CE_DIV_A - 1);

    // ---------------- synchronisers ----------------
    logic rst_sync_n;
    logic lk;

    pll_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
        .clk   (clk_sys),
        .clr_n (rst_n),
        .d     (1'b1),
        .q     (rst_sync_n)
    );

    pll_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk_sys),
        .clr_n (rst_n),
        .d     (pll_locked),
        .q     (lk)
    );

    // ---------------- FSM / counters ----------------
    state_t              state,      state_nxt;
    logic [STABLE_W-1:0] stable_cnt, stable_nxt;
    logic [HOLD_W-1:0]   hold_cnt,   hold_nxt;
    logic [DIV_W-1:0]    div_cnt,    div_nxt;
    logic                loss_evt;
    logic                strobes_on;

    function automatic logic [DIV_W-1:0] div_step(input logic [DIV_W-1:0] cur);
        return (cur == DIV_LAST) ? '0 : cur + 1'b1;
    endfunction

    always_comb begin
        state_nxt  = state;
        stable_nxt = stable_cnt;
        hold_nxt   = hold_cnt;
        div_nxt    = div_cnt;
        loss_evt   = 1'b0;

        unique case (state)
            WAIT_LOCK: begin
                stable_nxt = '0;
                hold_nxt   = '0;
                div_nxt    = '0;
                if (lk) begin
                    state_nxt = STABLE;
                end
            end
            STABLE: begin
                div_nxt = '0;
                if (!lk) begin
                    state_nxt  = WAIT_LOCK;
                    stable_nxt = '0;
                end else if (stable_cnt == STABLE_LAST) begin
                    state_nxt  = HOLD;
                    stable_nxt = '0;
                    hold_nxt   = '0;
                end else begin
                    stable_nxt = stable_cnt + 1'b1;
                end
            end
            HOLD: begin
                // Lock loss takes priority over the hold terminal count.
                if (!lk) begin
                    state_nxt = WAIT_LOCK;
                    loss_evt  = 1'b1;
                    hold_nxt  = '0;
                    div_nxt   = '0;
                end else begin
                    div_nxt = div_step(div_cnt);
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = RUN;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
            end
            RUN: begin
                if (!lk) begin
                    state_nxt = WAIT_LOCK;
                    loss_evt  = 1'b1;
                    div_nxt   = '0;
                end else begin
                    div_nxt = div_step(div_cnt);
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase
    end

    // The outputs are registered from next-state values. This keeps every
    // output aligned with the state and divider it describes.
    assign strobes_on = (state_nxt == HOLD) || (state_nxt == RUN);

    always_ff @(posedge clk_sys or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
            hold_cnt   <= '0;
            div_cnt    <= '0;
            sys_reset  <= 1'b1;
            ready      <= 1'b0;
            ce_a       <= 1'b0;
            ce_b       <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            state      <= state_nxt;
            stable_cnt <= stable_nxt;
            hold_cnt   <= hold_nxt;
            div_cnt    <= div_nxt;
            sys_reset  <= (state_nxt != RUN);
            ready      <= (state_nxt == RUN);
            ce_a       <= strobes_on && ((div_nxt & A_MASK) == '0);
            ce_b       <= strobes_on && (div_nxt == '0);
            lock_lost  <= lock_lost | loss_evt;
        end
    end

    // ---------------- lock-loss counter ----------------
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt;

    always_ff @(posedge clk_sys or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            loss_cnt <= '0;
        end else if (loss_evt && (loss_cnt != LOSS_CNT_MAX)) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end

    assign lock_loss_cnt = loss_cnt;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

    localparam int SYNC_STAGES = 2;
    localparam int LSC         = 8;
    localparam int RHC         = 32;
    localparam int DIV_A       = 4;
    localparam int DIV_B       = 16;
    localparam int LOCK_LAT    = SYNC_STAGES + 1 + LSC + RHC;
    localparam int DROP_LAT    = SYNC_STAGES + 1;

    logic       clk_sys    = 1'b0;
    logic       rst_n      = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sys_reset;
    logic       ready;
    logic       ce_a;
    logic       ce_b;
    logic       lock_lost;
    logic [7:0] lock_loss_cnt;

    pll_lock_sequencer #(
        .SYNC_STAGES        (SYNC_STAGES),
        .LOCK_STABLE_CYCLES (LSC),
        .RESET_HOLD_CYCLES  (RHC),
        .CE_DIV_A           (DIV_A),
        .CE_DIV_B           (DIV_B)
    ) dut (
        .clk_sys       (clk_sys),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .sys_reset     (sys_reset),
        .ready         (ready),
        .ce_a          (ce_a),
        .ce_b          (ce_b),
        .lock_lost     (lock_lost),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        string tag;
        int    value;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   exp_loss  = 0;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.value);
        end
    endtask

    // Returns the number of clock edges until sys_reset reaches level, or -1.
    task automatic wait_sys_reset(input logic level, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (sys_reset === level) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic note_loss();
`ifdef PLL_LOCK_LOSS_CNT_EN
        if (exp_loss < 255) exp_loss++;
`endif
    endtask

    task automatic lock_to_run(input string tag);
        int n;
        pll_locked = 1'b1;
        expect_val(tag, LOCK_LAT);
        wait_sys_reset(1'b0, LOCK_LAT + 20, n);
        pop_check(n);
    endtask

    task automatic drop_lock(input string tag);
        int n;
        pll_locked = 1'b0;
        expect_val(tag, DROP_LAT);
        wait_sys_reset(1'b1, DROP_LAT + 10, n);
        pop_check(n);
        note_loss();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        // 1: power-up with the PLL unlocked.
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        repeat (5) tick();
        check("rst_sys_reset", sys_reset, 1);
        check("rst_ready", ready, 0);
        check("rst_ce", {ce_b, ce_a}, 0);
        check("rst_lock_lost", lock_lost, 0);
        check("rst_loss_cnt", lock_loss_cnt, 0);
        rst_n = 1'b1;
        expect_val("unlocked_activity", 0);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ce_a !== 1'b0 || ce_b !== 1'b0 || ready !== 1'b0 || sys_reset !== 1'b1) bad++;
        end
        pop_check(bad);

        // 3: one-cycle glitch after 5 STABLE cycles restarts the stable count.
        pll_locked = 1'b1;
        repeat (7) tick();
        pll_locked = 1'b0;
        tick();
        lock_to_run("glitch_relock_latency");
        check("glitch_lock_lost", lock_lost, 0);
        check("glitch_ready", ready, 1);

        // 2: strobe pattern from the first RUN cycle onwards.
        for (int k = 0; k < 2 * DIV_B; k++) begin
            expect_val("ce_pattern", ((k % DIV_A) == 0 ? 1 : 0) + ((k % DIV_B) == 0 ? 2 : 0));
        end
        for (int k = 0; k < 2 * DIV_B; k++) begin
            pop_check({30'd0, ce_b, ce_a});
            tick();
        end

        // 4: lock loss in RUN, then relock.
        drop_lock("run_loss_latency");
        check("loss_ready", ready, 0);
        check("loss_ce", {ce_b, ce_a}, 0);
        check("loss_lock_lost", lock_lost, 1);
        check("loss_cnt_one", lock_loss_cnt, exp_loss);
        expect_val("loss_ce_quiet", 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ce_a !== 1'b0 || ce_b !== 1'b0) bad++;
        end
        pop_check(bad);
        lock_to_run("relock_latency");
        check("relock_lock_lost", lock_lost, 1);
        drop_lock("run_loss2_latency");

        // Lock drop on the hold terminal-count cycle: lock loss wins.
        pll_locked = 1'b1;
        repeat (LOCK_LAT - 3) tick();
        pll_locked = 1'b0;
        expect_val("tc_vs_loss_release", 0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sys_reset !== 1'b1 || ready !== 1'b0) bad++;
        end
        pop_check(bad);
        note_loss();
        check("tc_vs_loss_cnt", lock_loss_cnt, exp_loss);

        // 5: asynchronous reset in HOLD at hold_cnt=10.
        pll_locked = 1'b1;
        repeat (SYNC_STAGES + 1 + LSC + 10) tick();
        check("pre_areset_hold", sys_reset, 1);
        rst_n = 1'b0;
        #1;
        check("areset_sys_reset", sys_reset, 1);
        check("areset_ready", ready, 0);
        check("areset_ce", {ce_b, ce_a}, 0);
        check("areset_lock_lost", lock_lost, 0);
        check("areset_loss_cnt", lock_loss_cnt, 0);
        exp_loss = 0;
        tick();
        tick();
        rst_n = 1'b1;
        lock_to_run("post_reset_latency");
        check("post_reset_ready", ready, 1);
        check("post_reset_ce", {ce_b, ce_a}, 3);

        // 6: 300 loss events from RUN.
        for (int i = 0; i < 300; i++) begin
            drop_lock("loop_loss_latency");
            check("loop_loss_cnt", lock_loss_cnt, exp_loss);
            lock_to_run("loop_lock_latency");
        end
`ifdef PLL_LOCK_LOSS_CNT_EN
        check("loss_cnt_saturated", lock_loss_cnt, 255);
`else
        check("loss_cnt_disabled", lock_loss_cnt, 0);
`endif
        check("final_lock_lost", lock_lost, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
